// File: rtl/seq_calc_if.sv
// rtl/seq_calc_if.sv - request/result bundle between a requester and seq_calc
interface seq_calc_if #(parameter int W = 16);
  logic         start;
  logic [2:0]   OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         done;
  logic [W-1:0] R;
  logic         ovf;
  logic         ovf_sticky;
  logic [W-1:0] acc;

  modport master (
    output start, OP, A, B,
    input  ready, done, R, ovf, ovf_sticky, acc
  );

  modport slave (
    input  start, OP, A, B,
    output ready, done, R, ovf, ovf_sticky, acc
  );
endinterface

// File: rtl/seq_calc.sv
// rtl/seq_calc.sv - handshaked W-bit calculator with shift-add multiplier and accumulator
module seq_calc #(
  parameter int W = 16
) (
  input logic clk,
  input logic rst,
  seq_calc_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam int PW = 2 * W;
  localparam logic [PW-1:0] HALF = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, FIN} stateT;

  stateT         state, nextState;
  logic          doneReg, ovfReg, stickyReg, mSign;
  logic [W-1:0]  rReg, accReg, mA, mB;
  logic [PW-1:0] prodP;
  logic [CW-1:0] count;

  logic [W-1:0]  aluR, accNext, absA, absB, lowP, mulR;
  logic          aluOvf, mulOvf;

  assign bus.ready      = (state == IDLE);
  assign bus.done       = doneReg;
  assign bus.R          = rReg;
  assign bus.ovf        = ovfReg;
  assign bus.ovf_sticky = stickyReg;
  assign bus.acc        = accReg;

  assign absA = bus.A[W-1] ? -bus.A : bus.A;
  assign absB = bus.B[W-1] ? -bus.B : bus.B;

  // Low W bits of -P equal the negation of P's low W bits, so only those are kept.
  assign lowP   = prodP[W-1:0];
  assign mulR   = mSign ? -lowP : lowP;
  assign mulOvf = mSign ? (prodP > HALF) : (prodP > (HALF - PW'(1)));

  always_comb begin
    aluR    = '0;
    aluOvf  = 1'b0;
    accNext = accReg;
    case (bus.OP)
      3'b000: begin
        aluR   = bus.A + bus.B;
        aluOvf = (bus.A[W-1] == bus.B[W-1]) && (aluR[W-1] != bus.A[W-1]);
      end
      3'b001: begin
        aluR   = bus.A - bus.B;
        aluOvf = (bus.A[W-1] != bus.B[W-1]) && (aluR[W-1] != bus.A[W-1]);
      end
      3'b010: begin
        aluR   = bus.B - bus.A;
        aluOvf = (bus.B[W-1] != bus.A[W-1]) && (aluR[W-1] != bus.B[W-1]);
      end
      3'b011: begin
        aluR   = absA;
        aluOvf = bus.A[W-1] && absA[W-1];
      end
      3'b101: begin
        aluR    = accReg + bus.A;
        aluOvf  = (accReg[W-1] == bus.A[W-1]) && (aluR[W-1] != accReg[W-1]);
        accNext = aluR;
      end
      3'b110: begin
        aluR    = accReg - bus.A;
        aluOvf  = (accReg[W-1] != bus.A[W-1]) && (aluR[W-1] != accReg[W-1]);
        accNext = aluR;
      end
      3'b111: accNext = '0;
      default: ;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start && bus.OP == 3'b100) nextState = MUL;
      MUL:     if (count == CW'(1)) nextState = FIN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      doneReg   <= 1'b0;
      rReg      <= '0;
      ovfReg    <= 1'b0;
      stickyReg <= 1'b0;
      accReg    <= '0;
      mA        <= '0;
      mB        <= '0;
      mSign     <= 1'b0;
      prodP     <= '0;
      count     <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.OP == 3'b100) begin
              mA    <= absA;
              mB    <= absB;
              mSign <= bus.A[W-1] ^ bus.B[W-1];
              prodP <= '0;
              count <= CW'(W);
            end else begin
              doneReg   <= 1'b1;
              rReg      <= aluR;
              ovfReg    <= aluOvf;
              accReg    <= accNext;
              stickyReg <= (bus.OP == 3'b111) ? 1'b0 : (stickyReg | aluOvf);
            end
          end
        end
        MUL: begin
          // W - count is the weight of the multiplier bit currently in mB[0].
          if (mB[0]) prodP <= prodP + ({{W{1'b0}}, mA} << (CW'(W) - count));
          mB    <= mB >> 1;
          count <= count - CW'(1);
        end
        FIN: begin
          doneReg   <= 1'b1;
          rReg      <= mulR;
          ovfReg    <= mulOvf;
          stickyReg <= stickyReg | mulOvf;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_calc.sv
// tb/tb_seq_calc.sv - directed bench for seq_calc at W=16
module tb_seq_calc;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seq_calc_if #(.W(16)) bus ();
  seq_calc #(.W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1; bus.OP = op; bus.A = a; bus.B = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic doMul(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic o);
    bit seen;
    seen = 1'b0; r = '0; o = 1'b0;
    issue(3'b100, a, b);
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (bus.done) begin
        seen = 1'b1; r = bus.R; o = bus.ovf;
      end else tick();
    end
    chk("mul_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int lowCnt, doneAt, doneCnt;
    logic [15:0] capR;
    logic capOvf;

    rst = 1'b1; bus.start = 1'b0; bus.OP = '0; bus.A = '0; bus.B = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_R", 32'(bus.R), 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("rst_acc", 32'(bus.acc), 32'h0);

    issue(3'b000, 16'h7FFF, 16'h0001);
    chk("add_done", 32'(bus.done), 32'd1);
    chk("add_R", 32'(bus.R), 32'h8000);
    chk("add_ovf", 32'(bus.ovf), 32'd1);
    chk("add_sticky", 32'(bus.ovf_sticky), 32'd1);

    bus.start = 1'b1; bus.OP = 3'b011; bus.A = 16'h8000; bus.B = 16'h0;
    tick();
    chk("abs_min_done", 32'(bus.done), 32'd1);
    chk("abs_min_R", 32'(bus.R), 32'h8000);
    chk("abs_min_ovf", 32'(bus.ovf), 32'd1);
    bus.A = 16'hFFFB;
    tick();
    bus.start = 1'b0;
    chk("abs_b2b_done", 32'(bus.done), 32'd1);
    chk("abs_R", 32'(bus.R), 32'h0005);
    chk("abs_ovf", 32'(bus.ovf), 32'd0);
    chk("abs_sticky_hold", 32'(bus.ovf_sticky), 32'd1);
    tick();
    chk("idle_done_low", 32'(bus.done), 32'd0);
    chk("idle_R_hold", 32'(bus.R), 32'h0005);

    issue(3'b001, 16'h8000, 16'h0001);
    chk("sub_R", 32'(bus.R), 32'h7FFF);
    chk("sub_ovf", 32'(bus.ovf), 32'd1);
    issue(3'b010, 16'h0003, 16'h0001);
    chk("rsub_R", 32'(bus.R), 32'hFFFE);
    chk("rsub_ovf", 32'(bus.ovf), 32'd0);

    lowCnt = 0; doneAt = -1; doneCnt = 0; capR = '0; capOvf = 1'b1;
    issue(3'b100, 16'hFFFD, 16'h0007);
    for (int k = 1; k <= 30; k++) begin
      if (!bus.ready) lowCnt++;
      if (bus.done) begin
        doneCnt++;
        if (doneAt < 0) begin doneAt = k; capR = bus.R; capOvf = bus.ovf; end
      end
      bus.start = (k == 5);
      bus.OP = 3'b000; bus.A = 16'h0001; bus.B = 16'h0001;
      tick();
    end
    bus.start = 1'b0;
    chk("mul_ready_low_cycles", 32'(lowCnt), 32'd17);
    chk("mul_done_cycle", 32'(doneAt), 32'd18);
    chk("mul_done_count", 32'(doneCnt), 32'd1);
    chk("mul_R", 32'(capR), 32'hFFEB);
    chk("mul_ovf", 32'(capOvf), 32'd0);
    chk("mul_R_hold", 32'(bus.R), 32'hFFEB);

    doMul(16'h0100, 16'h0100, capR, capOvf);
    chk("mul_big_R", 32'(capR), 32'h0000);
    chk("mul_big_ovf", 32'(capOvf), 32'd1);
    doMul(16'h8000, 16'h0001, capR, capOvf);
    chk("mul_min_pos_R", 32'(capR), 32'h8000);
    chk("mul_min_pos_ovf", 32'(capOvf), 32'd0);
    doMul(16'h8000, 16'hFFFF, capR, capOvf);
    chk("mul_min_neg_R", 32'(capR), 32'h8000);
    chk("mul_min_neg_ovf", 32'(capOvf), 32'd1);
    chk("mul_sticky", 32'(bus.ovf_sticky), 32'd1);

    issue(3'b111, 16'h0, 16'h0);
    chk("clr_R", 32'(bus.R), 32'h0);
    chk("clr_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("clr_acc", 32'(bus.acc), 32'h0);
    issue(3'b101, 16'h0005, 16'h0);
    chk("acc_add_acc", 32'(bus.acc), 32'h0005);
    issue(3'b110, 16'h0008, 16'h0);
    chk("acc_sub_R", 32'(bus.R), 32'hFFFD);
    chk("acc_sub_acc", 32'(bus.acc), 32'hFFFD);
    chk("acc_sub_ovf", 32'(bus.ovf), 32'd0);
    issue(3'b101, 16'h7FFF, 16'h0);
    chk("acc_big_R", 32'(bus.R), 32'h7FFC);
    chk("acc_big_ovf", 32'(bus.ovf), 32'd0);
    issue(3'b101, 16'h0004, 16'h0);
    chk("acc_wrap_acc", 32'(bus.acc), 32'h8000);
    chk("acc_wrap_ovf", 32'(bus.ovf), 32'd1);
    chk("acc_wrap_sticky", 32'(bus.ovf_sticky), 32'd1);
    issue(3'b111, 16'h0, 16'h0);
    chk("clr2_R", 32'(bus.R), 32'h0);
    chk("clr2_ovf", 32'(bus.ovf), 32'd0);
    chk("clr2_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("clr2_acc", 32'(bus.acc), 32'h0);

    issue(3'b101, 16'h0003, 16'h0);
    issue(3'b100, 16'h0003, 16'h0003);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_R", 32'(bus.R), 32'h0);
    chk("abort_acc", 32'(bus.acc), 32'h0);
    doneCnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done) doneCnt++;
      tick();
    end
    chk("abort_no_done", 32'(doneCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_calc.md
Name: seq_calc

Overview:
- Clocked, handshaked successor to the combinational add/sub/abs calculator, parametrised in operand width W.
- Adds a multi-cycle signed shift-add multiplier, an internal accumulator register with accumulate/clear ops, registered outputs and a sticky overflow flag.
- Sits between a requester (issues start/OP/A/B) and a consumer of R/ovf. Results are valid on a one-cycle done pulse.

Parameters:
- W, 16, operand/result width in bits (two's complement); legal W >= 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where ready=1.
- OP  input  3  opcode, sampled with start.
- A  input  W  signed operand, sampled with start.
- B  input  W  signed operand, sampled with start.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse; R/ovf are valid and new this cycle.
- R  output  W  registered result; holds until the next done.
- ovf  output  1  overflow flag for the current R; holds with R.
- ovf_sticky  output  1  OR of every ovf since reset or the last OP=111.
- acc  output  W  current accumulator value.

Behaviour:
- Reset (rst=1 at an edge) sets state IDLE, ready=1, done=0, R=0, ovf=0, ovf_sticky=0, acc=0. Reset overrides start. Reset during MUL aborts the multiply; no done follows.
- Opcodes:
  - 000: R=A+B
  - 001: R=A-B
  - 010: R=B-A
  - 011: R=|A|
  - 100: R=A*B
  - 101: acc=acc+A, R=new acc
  - 110: acc=acc-A, R=new acc
  - 111: acc=0, R=0, ovf=0, ovf_sticky cleared
- All arithmetic is W-bit two's complement with wrap-around. ovf = signed overflow.
- |A| with A=-2^(W-1) gives R=A and ovf=1.
- For 101/110, acc takes the wrapped value even when ovf=1.
- Opcodes other than 100 are single-cycle: accepted at edge N, then done=1, R/ovf updated and acc updated during cycle N+1. ready stays 1, so back-to-back starts give done every cycle.
- States: IDLE, MUL, FIN.
  - IDLE: start & OP=100 -> MUL. Other opcodes stay in IDLE.
  - On entry to MUL:
    - latch mA=|A| and mB=|B| as W-bit unsigned (|-2^(W-1)| = 2^(W-1) fits);
    - latch sign = A[W-1]^B[W-1];
    - clear the 2W-bit product P;
    - load count=W;
    - ready=0.
  - MUL, once per cycle: if mB[0], P += mA<<(W-count). Shift mB right, decrement count. When count reaches 0 -> FIN. MUL lasts exactly W cycles.
  - FIN (one cycle):
    - R = low W bits of (sign ? -P : P).
    - ovf=1 if P > 2^(W-1)-1 (sign=0) or P > 2^(W-1) (sign=1).
    - done=1 in the cycle after FIN. Return to IDLE with ready=1 in that same cycle.
  - Multiply latency: start accepted at edge N -> done high during cycle N+W+2. ready is low from cycle N+1 through N+W+1.
- start while ready=0 is ignored, with no side effects. A/B/OP may change freely after acceptance.
- ovf_sticky is set in the same cycle as any done with ovf=1. It is cleared only by reset or OP=111. If 111 is issued, the result is ovf_sticky=0.
- done is 0 in all cycles not listed above. R/ovf never change except at done.

Test Plan:
- Reset, then start OP=000 A=0x7FFF B=0x0001 -> next cycle done=1, R=0x8000, ovf=1, ovf_sticky=1.
- OP=011 A=0x8000 -> R=0x8000, ovf=1. OP=011 A=0xFFFB -> R=0x0005, ovf=0. Back-to-back starts give done on consecutive cycles.
- OP=100 A=0xFFFD B=0x0007 -> ready low 17 cycles, done at N+18, R=0xFFEB, ovf=0. A second start issued mid-multiply is ignored: exactly one done, same R.
- OP=100 A=0x0100 B=0x0100 -> R=0x0000, ovf=1. OP=100 A=0x8000 B=0x0001 -> R=0x8000, ovf=0. OP=100 A=0x8000 B=0xFFFF -> R=0x8000, ovf=1.
- OP=111; OP=101 A=5; OP=110 A=8 -> R=acc=0xFFFD, ovf=0. Then OP=101 A=0x7FFF -> R=0x7FFC, ovf=0. OP=111 clears acc, R and ovf_sticky.
- Start OP=100, assert rst 5 cycles later -> ready=1, R=0, acc=0, and no done pulse ever follows.
